render_scanner: RTL and testbench
=================================

RENDER_SCANNER -- requirements
Module: render_scanner

Interface
REQ-001 SHALL have parameter NUM_OBJ, default 8, object table depth (>=1).
REQ-002 SHALL have parameter FB_WIDTH, default 320, framebuffer columns.
REQ-003 SHALL have parameter FB_HEIGHT, default 180, framebuffer rows.
REQ-004 SHALL have parameters STATIC_COLOR 16'hFFFF, DYN_COLOR 16'hF800, BG_COLOR 16'h0000, RGB565 fill colours.
REQ-005 SHALL have port clk_in  input  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst_in  input  1  synchronous, active-high reset.
REQ-007 SHALL have port obj_valid_in  input  1  object-load request.
REQ-008 SHALL have port obj_ready_out  output  1  table can accept an object this cycle.
REQ-009 SHALL have port obj_id_in  input  2  shape type: 00 none, 01 filled circle, 10 filled rect, 11 rect outline.
REQ-010 SHALL have port obj_static_in  input  1  selects STATIC_COLOR (1) or DYN_COLOR (0).
REQ-011 SHALL have ports obj_x1_in, obj_x2_in  input  11  x coordinates, framebuffer space, unsigned.
REQ-012 SHALL have ports obj_y1_in, obj_y2_in  input  10  y coordinates, framebuffer space, unsigned.
REQ-013 SHALL have port start_in  input  1  single-cycle request to render the loaded table.
REQ-014 SHALL have ports fb_we_out 1, fb_addr_out $clog2(FB_WIDTH*FB_HEIGHT), fb_data_out 16  outputs  framebuffer write port.
REQ-015 SHALL have ports busy_out 1, done_out 1, obj_count_out $clog2(NUM_OBJ+1)  outputs  status.

Function
REQ-016 SHALL implement FSM states IDLE, SCAN, FLUSH; IDLE->SCAN on start_in; SCAN->FLUSH after last pixel issued; FLUSH->IDLE after the final write.
REQ-017 An object SHALL be accepted when obj_valid_in && obj_ready_out, written to slot obj_count_out, and the count SHALL increment.
REQ-018 obj_ready_out SHALL be 1 only in IDLE with obj_count_out < NUM_OBJ; a load at full SHALL be dropped with no state change.
REQ-019 A load and start_in in the same IDLE cycle SHALL both take effect, and the new object SHALL be included in that render.
REQ-020 start_in in SCAN or FLUSH SHALL be ignored; start_in with zero objects SHALL render a full BG_COLOR frame.
REQ-021 SCAN SHALL visit pixels raster order, x 0..FB_WIDTH-1 inner, y 0..FB_HEIGHT-1 outer, one per cycle, no stalls.
REQ-022 Hit test SHALL be a 2-stage pipeline: stage 1 registers per-slot hits, stage 2 registers fb_we_out/fb_addr_out/fb_data_out.
REQ-023 First write SHALL assert 2 cycles after the cycle start_in is accepted; a frame SHALL be exactly FB_WIDTH*FB_HEIGHT consecutive write cycles.
REQ-024 fb_addr_out SHALL equal y*FB_WIDTH + x for the pixel written.
REQ-025 Circle hit: dx=x-x1, dy=y-y1 signed 12-bit, radius r=obj_x2[7:0]; hit iff dx*dx+dy*dy <= r*r, evaluated at >=25-bit width without overflow.
REQ-026 Filled-rect hit iff x1<=x<=x2 and y1<=y<=y2; x1>x2 or y1>y2 SHALL never hit.
REQ-027 Outline hit iff filled-rect hit and (x==x1 or x==x2 or y==y1 or y==y2).
REQ-028 Type 00 slots SHALL occupy a slot and never hit.
REQ-029 On multiple hits the lowest slot index SHALL win; no hit SHALL give BG_COLOR.
REQ-030 done_out SHALL pulse one cycle, the cycle after the last fb_we_out, as FSM returns to IDLE.
REQ-031 On return to IDLE obj_count_out SHALL clear to 0; the next frame requires reloading.
REQ-032 busy_out SHALL be 1 in SCAN and FLUSH, 0 in IDLE.

Reset
REQ-033 rst_in SHALL force IDLE, obj_count_out=0, fb_we_out=0, fb_addr_out=0, fb_data_out=0, busy_out=0, done_out=0, obj_ready_out=1 from the next cycle.
REQ-034 rst_in mid-SCAN SHALL abort the frame with no further writes and no done_out pulse; table contents need not clear, but count SHALL.
REQ-035 rst_in SHALL take priority over simultaneous start_in or object loads.

Verification
REQ-036 Empty table, start_in -> 57600 writes, all data 16'h0000, addresses 0..57599 in order, done_out one cycle after the last.
REQ-037 Circle x1=100,y1=50,r=10 static -> pixel (110,50) 16'hFFFF, (111,50) 16'h0000, (107,57) hit (49+49<=100).
REQ-038 Slot0 dynamic rect (10,10)-(20,20), slot1 static rect (15,15)-(30,30) -> (15,15) 16'hF800, (25,25) 16'hFFFF.
REQ-039 Outline (0,0)-(319,179) -> (0,90) and (319,179) hit, (1,1) BG_COLOR; inverted rect x1=50,x2=40 -> no hits.
REQ-040 Load NUM_OBJ objects -> obj_ready_out=0, extra valid dropped, count stays NUM_OBJ; load+start same cycle -> object drawn.
REQ-041 rst_in at pixel 1000 of SCAN -> fb_we_out 0 next cycle, no done_out, obj_ready_out=1, count=0.

Source files
------------

// File: rtl/render_scanner.sv
// render_scanner: rasterises a small object table (circles, filled and outlined
// rectangles) into an RGB565 framebuffer, one pixel per clock in raster order.
module render_scanner #(
  parameter int          NUM_OBJ      = 8,
  parameter int          FB_WIDTH     = 320,
  parameter int          FB_HEIGHT    = 180,
  parameter logic [15:0] STATIC_COLOR = 16'hFFFF,
  parameter logic [15:0] DYN_COLOR    = 16'hF800,
  parameter logic [15:0] BG_COLOR     = 16'h0000,
  localparam int         AW           = $clog2(FB_WIDTH * FB_HEIGHT),
  localparam int         CW           = $clog2(NUM_OBJ + 1)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          obj_valid_in,
  output logic          obj_ready_out,
  input  logic [1:0]    obj_id_in,
  input  logic          obj_static_in,
  input  logic [10:0]   obj_x1_in,
  input  logic [10:0]   obj_x2_in,
  input  logic [9:0]    obj_y1_in,
  input  logic [9:0]    obj_y2_in,
  input  logic          start_in,
  output logic          fb_we_out,
  output logic [AW-1:0] fb_addr_out,
  output logic [15:0]   fb_data_out,
  output logic          busy_out,
  output logic          done_out,
  output logic [CW-1:0] obj_count_out
);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, FLUSH = 2'd2} state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [CW-1:0]        r_count;
  logic [10:0]          r_x;
  logic [9:0]           r_y;
  logic [AW-1:0]        r_pix;
  logic                 r_s1_valid;
  logic [AW-1:0]        r_s1_addr;
  logic [NUM_OBJ-1:0]   r_hit;
  logic                 r_fb_we;
  logic [AW-1:0]        r_fb_addr;
  logic [15:0]          r_fb_data;
  logic                 r_done;
  logic                 w_start_go;
  logic                 w_scan;
  logic                 w_flush_end;
  logic                 w_load;
  logic                 w_last_pix;
  logic [NUM_OBJ-1:0]   w_slot_hit;
  logic [NUM_OBJ-1:0]   w_static;
  logic [15:0]          w_color;

  // ---------------- FSM ----------------
  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start_in) w_state_next = SCAN;
      SCAN:    if (w_last_pix) w_state_next = FLUSH;
      FLUSH:   if (r_fb_we && !r_s1_valid) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // FLUSH ends once the last pixel has left stage 1 and is on the write port.
  always_comb begin
    obj_ready_out = (r_state == IDLE) && (r_count < CW'(NUM_OBJ));
    busy_out      = (r_state != IDLE);
    w_start_go    = (r_state == IDLE) && start_in;
    w_scan        = (r_state == SCAN);
    w_flush_end   = (r_state == FLUSH) && r_fb_we && !r_s1_valid;
  end

  assign w_load     = obj_valid_in && obj_ready_out && !rst_in;
  assign w_last_pix = (r_x == 11'(FB_WIDTH - 1)) && (r_y == 10'(FB_HEIGHT - 1));

  always_ff @(posedge clk_in) begin
    if (rst_in)           r_count <= '0;
    else if (w_flush_end) r_count <= '0;
    else if (w_load)      r_count <= r_count + 1'b1;
  end

  // ---------------- raster counters ----------------
  always_ff @(posedge clk_in) begin
    if (rst_in || w_start_go) begin
      r_x   <= '0;
      r_y   <= '0;
      r_pix <= '0;
    end else if (w_scan) begin
      if (r_x == 11'(FB_WIDTH - 1)) begin
        r_x <= '0;
        r_y <= r_y + 10'd1;
      end else begin
        r_x <= r_x + 11'd1;
      end
      r_pix <= r_pix + 1'b1;
    end
  end

  // ---------------- object slots and per-slot hit test ----------------
  for (genvar gi = 0; gi < NUM_OBJ; gi++) begin : g_slot
    logic [1:0]         r_obj_id;
    logic               r_obj_static;
    logic [10:0]        r_obj_x1;
    logic [10:0]        r_obj_x2;
    logic [9:0]         r_obj_y1;
    logic [9:0]         r_obj_y2;
    logic signed [11:0] w_dx;
    logic signed [11:0] w_dy;
    logic signed [24:0] w_dx_e;
    logic signed [24:0] w_dy_e;
    logic signed [24:0] w_dist;
    logic [24:0]        w_r2;
    logic               w_circ;
    logic               w_in_rect;
    logic               w_on_edge;
    logic               w_shape;

    always_ff @(posedge clk_in) begin
      if (w_load && (r_count == CW'(gi))) begin
        r_obj_id     <= obj_id_in;
        r_obj_static <= obj_static_in;
        r_obj_x1     <= obj_x1_in;
        r_obj_x2     <= obj_x2_in;
        r_obj_y1     <= obj_y1_in;
        r_obj_y2     <= obj_y2_in;
      end
    end

    // Circle radius lives in the low byte of x2; 25-bit squares cannot overflow.
    assign w_dx      = $signed({1'b0, r_x}) - $signed({1'b0, r_obj_x1});
    assign w_dy      = $signed({2'b0, r_y}) - $signed({2'b0, r_obj_y1});
    assign w_dx_e    = 25'(w_dx);
    assign w_dy_e    = 25'(w_dy);
    assign w_dist    = w_dx_e * w_dx_e + w_dy_e * w_dy_e;
    assign w_r2      = 25'(r_obj_x2[7:0]) * 25'(r_obj_x2[7:0]);
    assign w_circ    = ($unsigned(w_dist) <= w_r2);
    assign w_in_rect = (r_x >= r_obj_x1) && (r_x <= r_obj_x2) &&
                       (r_y >= r_obj_y1) && (r_y <= r_obj_y2);
    assign w_on_edge = (r_x == r_obj_x1) || (r_x == r_obj_x2) ||
                       (r_y == r_obj_y1) || (r_y == r_obj_y2);

    always_comb begin
      case (r_obj_id)
        2'b01:   w_shape = w_circ;
        2'b10:   w_shape = w_in_rect;
        2'b11:   w_shape = w_in_rect && w_on_edge;
        default: w_shape = 1'b0;
      endcase
    end

    assign w_slot_hit[gi] = w_shape && (CW'(gi) < r_count);
    assign w_static[gi]   = r_obj_static;
  end

  // ---------------- stage 1: registered hits ----------------
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_s1_valid <= 1'b0;
      r_s1_addr  <= '0;
      r_hit      <= '0;
    end else begin
      r_s1_valid <= w_scan;
      r_s1_addr  <= r_pix;
      r_hit      <= w_slot_hit;
    end
  end

  // Walking down from the top slot lets the lowest index overwrite last.
  always_comb begin
    w_color = BG_COLOR;
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (r_hit[i]) w_color = w_static[i] ? STATIC_COLOR : DYN_COLOR;
    end
  end

  // ---------------- stage 2: framebuffer write port ----------------
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_fb_we   <= 1'b0;
      r_fb_addr <= '0;
      r_fb_data <= '0;
      r_done    <= 1'b0;
    end else begin
      r_fb_we <= r_s1_valid;
      r_done  <= w_flush_end;
      if (r_s1_valid) begin
        r_fb_addr <= r_s1_addr;
        r_fb_data <= w_color;
      end
    end
  end

  assign fb_we_out     = r_fb_we;
  assign fb_addr_out   = r_fb_addr;
  assign fb_data_out   = r_fb_data;
  assign done_out      = r_done;
  assign obj_count_out = r_count;

endmodule

// File: tb/tb_render_scanner.sv
// tb_render_scanner: frame-level checks of render_scanner against a pixel-rule
// model of the object table, on a reduced 120x60 framebuffer with 4 slots.
module tb_render_scanner;
  localparam int N    = 4;
  localparam int W    = 120;
  localparam int H    = 60;
  localparam int NPIX = W * H;
  localparam int AW   = $clog2(NPIX);
  localparam int CW   = $clog2(N + 1);
  localparam logic [15:0] C_ST = 16'hFFFF;
  localparam logic [15:0] C_DY = 16'hF800;
  localparam logic [15:0] C_BG = 16'h0000;

  logic          clk = 1'b0;
  logic          rst_in = 1'b1;
  logic          obj_valid_in = 1'b0;
  logic          obj_ready_out;
  logic [1:0]    obj_id_in = '0;
  logic          obj_static_in = 1'b0;
  logic [10:0]   obj_x1_in = '0;
  logic [10:0]   obj_x2_in = '0;
  logic [9:0]    obj_y1_in = '0;
  logic [9:0]    obj_y2_in = '0;
  logic          start_in = 1'b0;
  logic          fb_we_out;
  logic [AW-1:0] fb_addr_out;
  logic [15:0]   fb_data_out;
  logic          busy_out;
  logic          done_out;
  logic [CW-1:0] obj_count_out;

  always #5 clk = ~clk;

  render_scanner #(.NUM_OBJ(N), .FB_WIDTH(W), .FB_HEIGHT(H)) dut (
    .clk_in(clk), .rst_in(rst_in),
    .obj_valid_in(obj_valid_in), .obj_ready_out(obj_ready_out),
    .obj_id_in(obj_id_in), .obj_static_in(obj_static_in),
    .obj_x1_in(obj_x1_in), .obj_x2_in(obj_x2_in),
    .obj_y1_in(obj_y1_in), .obj_y2_in(obj_y2_in),
    .start_in(start_in),
    .fb_we_out(fb_we_out), .fb_addr_out(fb_addr_out), .fb_data_out(fb_data_out),
    .busy_out(busy_out), .done_out(done_out), .obj_count_out(obj_count_out)
  );

  typedef struct {int id; int st; int x1; int x2; int y1; int y2;} obj_t;
  obj_t m_objs[$];

  int total = 0;
  int bad   = 0;

  logic [15:0] cap_fb [NPIX];
  int cap_writes, cap_order_err, cap_gaps, cap_lat, cap_busy_low;
  int cap_done_ok, cap_timeout, cap_after_bad;
  int mm_x, mm_y;
  logic [15:0] mm_got, mm_exp;

  // Colour a pixel from the loaded list: first object (lowest slot) that covers it.
  function automatic logic [15:0] model_pixel(int x, int y);
    foreach (m_objs[i]) begin
      bit in_rect;
      bit hit;
      int r;
      r = m_objs[i].x2 % 256;
      in_rect = (x >= m_objs[i].x1) && (x <= m_objs[i].x2) &&
                (y >= m_objs[i].y1) && (y <= m_objs[i].y2);
      case (m_objs[i].id)
        1: hit = ((x - m_objs[i].x1) * (x - m_objs[i].x1) +
                  (y - m_objs[i].y1) * (y - m_objs[i].y1)) <= r * r;
        2: hit = in_rect;
        3: hit = in_rect && (x == m_objs[i].x1 || x == m_objs[i].x2 ||
                             y == m_objs[i].y1 || y == m_objs[i].y2);
        default: hit = 1'b0;
      endcase
      if (hit) return (m_objs[i].st != 0) ? C_ST : C_DY;
    end
    return C_BG;
  endfunction

  function automatic int model_mismatches();
    int n;
    n = 0;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        logic [15:0] e;
        e = model_pixel(x, y);
        if (cap_fb[y * W + x] !== e) begin
          if (n == 0) begin
            mm_x = x; mm_y = y; mm_got = cap_fb[y * W + x]; mm_exp = e;
          end
          n++;
        end
      end
    end
    return n;
  endfunction

  task automatic load_obj(input int id, input int st, input int x1, input int x2,
                          input int y1, input int y2);
    obj_t o;
    obj_id_in = 2'(id); obj_static_in = st[0];
    obj_x1_in = 11'(x1); obj_x2_in = 11'(x2);
    obj_y1_in = 10'(y1); obj_y2_in = 10'(y2);
    obj_valid_in = 1'b1;
    o.id = id; o.st = st; o.x1 = x1; o.x2 = x2; o.y1 = y1; o.y2 = y2;
    if (m_objs.size() < N) m_objs.push_back(o);
    @(posedge clk); #1;
    obj_valid_in = 1'b0;
  endtask

  // Pulses start (plus any load already on the inputs) and records the whole frame.
  task automatic run_frame(input int mid_start_cycle);
    bit prev_we;
    bit done_seen;
    cap_writes = 0; cap_order_err = 0; cap_gaps = 0; cap_lat = -1;
    cap_busy_low = 0; cap_done_ok = 0; cap_timeout = 0; cap_after_bad = 0;
    prev_we = 1'b0; done_seen = 1'b0;
    start_in = 1'b1;
    @(posedge clk); #1;
    start_in = 1'b0; obj_valid_in = 1'b0;
    for (int n = 1; n <= NPIX + 30 && !done_seen; n++) begin
      @(posedge clk); #1;
      if (fb_we_out) begin
        if (cap_lat < 0) cap_lat = n;
        if (!prev_we && cap_writes > 0) cap_gaps++;
        if (fb_addr_out != AW'(cap_writes)) cap_order_err++;
        if (cap_writes < NPIX) cap_fb[cap_writes] = fb_data_out;
        cap_writes++;
      end
      if (done_out) begin
        done_seen = 1'b1;
        cap_done_ok = (prev_we && !fb_we_out && !busy_out) ? 1 : 0;
      end else if (!busy_out) begin
        cap_busy_low++;
      end
      prev_we = fb_we_out;
      start_in = (n == mid_start_cycle);
    end
    start_in = 1'b0;
    if (!done_seen) cap_timeout = 1;
    @(posedge clk); #1;
    if (done_out || fb_we_out || busy_out) cap_after_bad = 1;
    $display("frame: writes=%0d first_write_cycle=%0d objects=%0d", cap_writes, cap_lat, m_objs.size());
  endtask

  task automatic test_reset();
    int we_seen;
    rst_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({fb_we_out, fb_addr_out, fb_data_out} !== {1'b0, AW'(0), 16'h0000}) begin
      $display("FAIL reset_fb got we=%0b addr=%0d data=%h want 0/0/0000", fb_we_out, fb_addr_out, fb_data_out); bad++;
    end
    total++;
    if ({busy_out, done_out, obj_ready_out, obj_count_out} !== {1'b0, 1'b0, 1'b1, CW'(0)}) begin
      $display("FAIL reset_status got busy=%0b done=%0b ready=%0b count=%0d want 0/0/1/0", busy_out, done_out, obj_ready_out, obj_count_out); bad++;
    end
    // reset held while start and a load are offered: both must be ignored
    start_in = 1'b1; obj_valid_in = 1'b1; obj_id_in = 2'b10;
    @(posedge clk); #1;
    rst_in = 1'b0; start_in = 1'b0; obj_valid_in = 1'b0;
    total++;
    if (busy_out !== 1'b0 || obj_count_out !== CW'(0)) begin
      $display("FAIL reset_priority got busy=%0b count=%0d want 0/0", busy_out, obj_count_out); bad++;
    end
    we_seen = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (fb_we_out || busy_out) we_seen++;
    end
    total++;
    if (we_seen !== 0) begin
      $display("FAIL reset_quiet got active_cycles=%0d want 0", we_seen); bad++;
    end
    $display("reset: done");
  endtask

  task automatic test_empty_frame();
    int mm;
    m_objs.delete();
    run_frame(0);
    mm = model_mismatches();
    total++;
    if (cap_writes !== NPIX) begin $display("FAIL empty_writes got=%0d want=%0d", cap_writes, NPIX); bad++; end
    total++;
    if (cap_order_err !== 0 || cap_gaps !== 0) begin
      $display("FAIL empty_order got order_err=%0d gaps=%0d want 0/0", cap_order_err, cap_gaps); bad++;
    end
    total++;
    if (cap_lat !== 2) begin $display("FAIL empty_latency got=%0d want=2", cap_lat); bad++; end
    total++;
    if (cap_done_ok !== 1 || cap_timeout !== 0 || cap_after_bad !== 0) begin
      $display("FAIL empty_done got done_ok=%0d timeout=%0d after_bad=%0d want 1/0/0", cap_done_ok, cap_timeout, cap_after_bad); bad++;
    end
    total++;
    if (cap_busy_low !== 0) begin $display("FAIL empty_busy got low_cycles=%0d want 0", cap_busy_low); bad++; end
    total++;
    if (mm !== 0) begin
      $display("FAIL empty_pixels got mismatches=%0d first (%0d,%0d)=%h want %h", mm, mm_x, mm_y, mm_got, mm_exp); bad++;
    end
    total++;
    if (obj_count_out !== CW'(0) || obj_ready_out !== 1'b1) begin
      $display("FAIL empty_after got count=%0d ready=%0b want 0/1", obj_count_out, obj_ready_out); bad++;
    end
  endtask

  task automatic test_shapes();
    int mm;
    m_objs.delete();
    load_obj(2, 0, 10, 20, 10, 20);
    load_obj(2, 1, 15, 30, 15, 30);
    load_obj(1, 1, 100, 10, 50, 0);
    total++;
    if (obj_count_out !== CW'(3)) begin $display("FAIL shapes_count got=%0d want=3", obj_count_out); bad++; end
    run_frame(0);
    mm = model_mismatches();
    total++;
    if (cap_fb[50 * W + 110] !== C_ST) begin $display("FAIL circle_edge got=%h want=%h", cap_fb[50 * W + 110], C_ST); bad++; end
    total++;
    if (cap_fb[50 * W + 111] !== C_BG) begin $display("FAIL circle_outside got=%h want=%h", cap_fb[50 * W + 111], C_BG); bad++; end
    total++;
    if (cap_fb[57 * W + 107] !== C_ST) begin $display("FAIL circle_diag got=%h want=%h", cap_fb[57 * W + 107], C_ST); bad++; end
    total++;
    if (cap_fb[15 * W + 15] !== C_DY) begin $display("FAIL overlap_low_slot got=%h want=%h", cap_fb[15 * W + 15], C_DY); bad++; end
    total++;
    if (cap_fb[25 * W + 25] !== C_ST) begin $display("FAIL overlap_second got=%h want=%h", cap_fb[25 * W + 25], C_ST); bad++; end
    total++;
    if (mm !== 0) begin
      $display("FAIL shapes_pixels got mismatches=%0d first (%0d,%0d)=%h want %h", mm, mm_x, mm_y, mm_got, mm_exp); bad++;
    end
  endtask

  task automatic test_outline();
    int mm;
    m_objs.delete();
    load_obj(2, 1, 50, 40, 20, 30);
    load_obj(3, 1, 0, W - 1, 0, H - 1);
    load_obj(0, 0, 0, W - 1, 0, H - 1);
    run_frame(0);
    mm = model_mismatches();
    total++;
    if (cap_fb[(H / 2) * W + 0] !== C_ST) begin $display("FAIL outline_left got=%h want=%h", cap_fb[(H / 2) * W], C_ST); bad++; end
    total++;
    if (cap_fb[NPIX - 1] !== C_ST) begin $display("FAIL outline_corner got=%h want=%h", cap_fb[NPIX - 1], C_ST); bad++; end
    total++;
    if (cap_fb[1 * W + 1] !== C_BG) begin $display("FAIL outline_inside got=%h want=%h", cap_fb[W + 1], C_BG); bad++; end
    total++;
    if (cap_fb[25 * W + 45] !== C_BG || cap_fb[30 * W + 60] !== C_BG) begin
      $display("FAIL inverted_or_none got=%h/%h want=%h", cap_fb[25 * W + 45], cap_fb[30 * W + 60], C_BG); bad++;
    end
    total++;
    if (mm !== 0) begin
      $display("FAIL outline_pixels got mismatches=%0d first (%0d,%0d)=%h want %h", mm, mm_x, mm_y, mm_got, mm_exp); bad++;
    end
  endtask

  task automatic test_full_table();
    int mm;
    m_objs.delete();
    load_obj(2, 0, 2, 6, 2, 6);
    load_obj(1, 1, 60, 5, 30, 0);
    load_obj(3, 0, 80, 100, 10, 20);
    load_obj(2, 1, 5, 15, 40, 50);
    total++;
    if (obj_ready_out !== 1'b0 || obj_count_out !== CW'(N)) begin
      $display("FAIL full_ready got ready=%0b count=%0d want 0/%0d", obj_ready_out, obj_count_out, N); bad++;
    end
    load_obj(2, 1, 0, W - 1, 0, H - 1);
    total++;
    if (obj_count_out !== CW'(N)) begin $display("FAIL full_drop got count=%0d want=%0d", obj_count_out, N); bad++; end
    run_frame(0);
    mm = model_mismatches();
    total++;
    if (mm !== 0) begin
      $display("FAIL full_pixels got mismatches=%0d first (%0d,%0d)=%h want %h", mm, mm_x, mm_y, mm_got, mm_exp); bad++;
    end
  endtask

  task automatic test_load_and_start();
    int mm;
    obj_t o;
    m_objs.delete();
    load_obj(2, 0, 20, 40, 20, 40);
    obj_id_in = 2'b10; obj_static_in = 1'b1;
    obj_x1_in = 11'd5; obj_x2_in = 11'd9; obj_y1_in = 10'd5; obj_y2_in = 10'd9;
    obj_valid_in = 1'b1;
    o.id = 2; o.st = 1; o.x1 = 5; o.x2 = 9; o.y1 = 5; o.y2 = 9;
    m_objs.push_back(o);
    run_frame(0);
    mm = model_mismatches();
    total++;
    if (cap_fb[7 * W + 7] !== C_ST) begin $display("FAIL load_start_pixel got=%h want=%h", cap_fb[7 * W + 7], C_ST); bad++; end
    total++;
    if (cap_writes !== NPIX || mm !== 0) begin
      $display("FAIL load_start_frame got writes=%0d mismatches=%0d want %0d/0", cap_writes, mm, NPIX); bad++;
    end
  endtask

  task automatic test_random();
    int mm;
    int n;
    for (int it = 0; it < 2; it++) begin
      m_objs.delete();
      n = $urandom_range(1, N);
      for (int k = 0; k < n; k++) begin
        load_obj($urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 130),
                 $urandom_range(0, 130), $urandom_range(0, 70), $urandom_range(0, 70));
      end
      run_frame(it == 0 ? 500 : 0);
      mm = model_mismatches();
      total++;
      if (cap_writes !== NPIX || cap_order_err !== 0 || cap_done_ok !== 1) begin
        $display("FAIL random_frame%0d got writes=%0d order_err=%0d done_ok=%0d want %0d/0/1", it, cap_writes, cap_order_err, cap_done_ok, NPIX); bad++;
      end
      total++;
      if (mm !== 0) begin
        $display("FAIL random_pixels%0d got mismatches=%0d first (%0d,%0d)=%h want %h", it, mm, mm_x, mm_y, mm_got, mm_exp); bad++;
      end
    end
  endtask

  task automatic test_midscan_reset();
    int writes;
    int late;
    m_objs.delete();
    load_obj(2, 1, 0, W - 1, 0, H - 1);
    start_in = 1'b1;
    @(posedge clk); #1;
    start_in = 1'b0;
    writes = 0;
    for (int n = 1; n <= 1000; n++) begin
      @(posedge clk); #1;
      if (fb_we_out) writes++;
    end
    rst_in = 1'b1;
    @(posedge clk); #1;
    rst_in = 1'b0;
    total++;
    if (writes !== 999) begin $display("FAIL midscan_prior_writes got=%0d want=999", writes); bad++; end
    total++;
    if (fb_we_out !== 1'b0 || busy_out !== 1'b0 || obj_ready_out !== 1'b1 || obj_count_out !== CW'(0)) begin
      $display("FAIL midscan_state got we=%0b busy=%0b ready=%0b count=%0d want 0/0/1/0", fb_we_out, busy_out, obj_ready_out, obj_count_out); bad++;
    end
    late = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (fb_we_out || done_out) late++;
    end
    total++;
    if (late !== 0) begin $display("FAIL midscan_quiet got active_cycles=%0d want 0", late); bad++; end
    $display("midscan reset: writes_before=%0d", writes);
  endtask

  initial begin
    test_reset();
    test_empty_frame();
    test_shapes();
    test_outline();
    test_full_table();
    test_load_and_start();
    test_random();
    test_midscan_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
